// File: rtl/dsp_inverse.sv
// Iterative inverse of the DSP forward path: recovers A from P, B, C, D
// using a restoring divider that yields one quotient bit per cycle.
module dsp_inverse #(
    parameter string OPERATION = "ADD"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [47:0] P,
    input  logic [17:0] B,
    input  logic [47:0] C,
    input  logic [17:0] D,
    output logic [17:0] A,
    output logic [17:0] rem,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic IS_SUB = (OPERATION == "SUBTRACT");

    typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

    state_t      state;
    logic [47:0] p_q;
    logic [47:0] c_q;
    logic [17:0] b_q;
    logic [17:0] d_q;
    logic [48:0] n_q;
    logic [48:0] q_q;
    logic [17:0] r_q;
    logic [5:0]  cnt;
    logic        neg_q;

    logic [18:0] trial;
    logic [18:0] trial_sub;
    logic        fits;
    logic [48:0] diff;
    logic [17:0] a_nxt;
    logic        err_nxt;

    // Restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial     = {r_q, n_q[48]};
        trial_sub = trial - {1'b0, b_q};
        fits      = (trial >= {1'b0, b_q});
    end

    always_comb begin
        a_nxt   = '0;
        diff    = q_q - {31'b0, d_q};
        err_nxt = (b_q == '0) || (r_q != '0) || neg_q;
        if (IS_SUB) begin
            if (q_q > {31'b0, d_q})
                err_nxt = 1'b1;
            else
                a_nxt = d_q - q_q[17:0];
        end else begin
            if ((q_q < {31'b0, d_q}) || (diff[48:18] != '0))
                err_nxt = 1'b1;
            else
                a_nxt = diff[17:0];
        end
        if (err_nxt)
            a_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p_q   <= '0;
            c_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            n_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            A     <= '0;
            rem   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_q   <= P;
                        b_q   <= B;
                        c_q   <= C;
                        d_q   <= D;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (IS_SUB) begin
                        n_q   <= {1'b0, p_q} + {1'b0, c_q};
                        neg_q <= 1'b0;
                    end else begin
                        n_q   <= {1'b0, p_q} - {1'b0, c_q};
                        neg_q <= (p_q < c_q);
                    end
                    q_q   <= '0;
                    r_q   <= '0;
                    cnt   <= 6'd48;
                    state <= DIV;
                end
                DIV: begin
                    n_q <= {n_q[47:0], 1'b0};
                    q_q <= {q_q[47:0], fits};
                    r_q <= fits ? trial_sub[17:0] : trial[17:0];
                    if (cnt == '0)
                        state <= FIN;
                    else
                        cnt <= cnt - 6'd1;
                end
                FIN: begin
                    A     <= a_nxt;
                    rem   <= r_q;
                    err   <= err_nxt;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
